// File: rtl/sa_stream_scheduler.sv
// Streaming front end for a free-running systolic array: skews accepted rows,
// deskews result columns and buffers aligned vectors under credit flow control.
module sa_stream_scheduler #(
   parameter int SA_SIZE         = 8,
   parameter int ACTIVATION_SIZE = 8,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [ACTIVATION_SIZE*SA_SIZE-1:0] in_data,
   input  logic                               in_last,
   output logic [ACTIVATION_SIZE*SA_SIZE-1:0] sa_inputs,
   input  logic [ACTIVATION_SIZE*SA_SIZE-1:0] sa_outputs,
   output logic                               sa_resetn,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [ACTIVATION_SIZE*SA_SIZE-1:0] out_data,
   output logic                               out_last,
   output logic                               busy,
   output logic                               done
);
   localparam int AW    = ACTIVATION_SIZE;
   localparam int VW    = ACTIVATION_SIZE * SA_SIZE;
   localparam int TAGS  = 2 * SA_SIZE;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              state_q, state_d;
   logic                accept, push, pop, push_last;
   logic                done_q;
   logic [CNT_W-1:0]    inflight_q, fifo_count_q;
   logic [CNT_W:0]      credits_used;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [TAGS-1:0]     tag_vld_p, tag_last_p;
   logic [VW-1:0]       aligned;
   logic [VW-1:0]       fifo_mem  [FIFO_DEPTH];
   logic                fifo_last [FIFO_DEPTH];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_count_q};
   assign in_ready     = (state_q != DRAIN) && (credits_used < DEPTH_C);
   assign accept       = in_valid && in_ready;
   assign push         = tag_vld_p[TAGS-1];
   assign push_last    = tag_vld_p[TAGS-1] && tag_last_p[TAGS-1];
   assign pop          = out_valid && out_ready;
   assign sa_resetn    = ~rst;
   assign busy         = (state_q != IDLE);
   assign done         = done_q;

   // Stage: input skew, row r delayed by r+1 edges; idle edges inject zero bubbles
   for (genvar r = 0; r < SA_SIZE; r++) begin : g_skew
      logic [AW-1:0] skew_p [r+1];
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int s = 0; s <= r; s++) skew_p[s] <= '0;
         end else begin
            skew_p[0] <= accept ? in_data[r*AW +: AW] : '0;
            for (int s = 1; s <= r; s++) skew_p[s] <= skew_p[s-1];
         end
      end
      assign sa_inputs[r*AW +: AW] = skew_p[r];
   end

   // Stage: output deskew, column c delayed by N-c edges so all columns align
   for (genvar c = 0; c < SA_SIZE; c++) begin : g_deskew
      localparam int D = SA_SIZE - c;
      logic [AW-1:0] dsk_p [D];
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int s = 0; s < D; s++) dsk_p[s] <= '0;
         end else begin
            dsk_p[0] <= sa_outputs[c*AW +: AW];
            for (int s = 1; s < D; s++) dsk_p[s] <= dsk_p[s-1];
         end
      end
      assign aligned[c*AW +: AW] = dsk_p[D-1];
   end

   // Stage: tag pipeline, tail coincides with the aligned stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld_p  <= '0;
         tag_last_p <= '0;
      end else begin
         tag_vld_p  <= {tag_vld_p[TAGS-2:0], accept};
         tag_last_p <= {tag_last_p[TAGS-2:0], accept && in_last};
      end
   end

   // Credits are registered counts, so a pop frees its slot only on the next edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q   <= '0;
         fifo_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         inflight_q <= inflight_q + CNT_W'(accept) - CNT_W'(push);
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
            2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
            default: fifo_count_q <= fifo_count_q;
         endcase
      end
   end

   // Stage: FIFO storage
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q]  <= aligned;
         fifo_last[wr_ptr_q] <= tag_last_p[TAGS-1];
      end
   end

   assign out_valid = (fifo_count_q != '0);
   assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : '0;
   assign out_last  = out_valid ? fifo_last[rd_ptr_q] : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= push_last;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = in_last ? DRAIN : RUN;
         RUN:     if (accept && in_last) state_d = DRAIN;
         DRAIN:   if (push_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && (fifo_count_q == FULL_C)));

endmodule

// File: tb/tb_sa_stream_scheduler.sv
// Directed bench for sa_stream_scheduler (N=4, 8-bit elements, 4-entry FIFO)
// driving a behavioural weight-stationary systolic array model.
module tb_sa_stream_scheduler;
   localparam int N  = 4;
   localparam int AW = 8;
   localparam int VW = N * AW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [VW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic [VW-1:0] sa_inputs;
   logic [VW-1:0] sa_outputs;
   logic          sa_resetn;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [VW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          done;

   int n_vec = 0;
   int n_err = 0;

   sa_stream_scheduler #(.SA_SIZE(N), .ACTIVATION_SIZE(AW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .sa_inputs(sa_inputs),
      .sa_outputs(sa_outputs), .sa_resetn(sa_resetn), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Behavioural array: activations move right, partial sums move down,
   // bottom-row sum leaves combinationally.
   logic [AW-1:0] W     [N][N];
   logic [AW-1:0] a_reg [N][N];
   logic [AW-1:0] p_reg [N][N];
   logic [AW-1:0] a_in_w [N][N];

   always_comb begin
      a_in_w = '{default: '0};
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            a_in_w[r][c] = (c == 0) ? sa_inputs[r*AW +: AW] : a_reg[r][(c == 0) ? 0 : c-1];
   end

   always @(posedge clk or negedge sa_resetn) begin
      if (!sa_resetn) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               a_reg[r][c] <= '0;
               p_reg[r][c] <= '0;
            end
      end else begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               a_reg[r][c] <= a_in_w[r][c];
               p_reg[r][c] <= ((r == 0) ? 8'd0 : p_reg[(r == 0) ? 0 : r-1][c]) + W[r][c] * a_in_w[r][c];
            end
      end
   end

   always_comb begin
      sa_outputs = '0;
      for (int c = 0; c < N; c++)
         sa_outputs[c*AW +: AW] = p_reg[N-2][c] + W[N-1][c] * a_in_w[N-1][c];
   end

   task automatic set_w(input bit ones);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            W[r][c] = (ones || (r == c)) ? 8'd1 : 8'd0;
   endtask

   function automatic logic [VW-1:0] rep(input int k);
      return {N{8'(k)}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   // Streaming stimulus tables
   logic [VW-1:0] vec_in  [32];
   logic [VW-1:0] vec_exp [32];
   logic          last_in [32];
   int            hold_sent, max_out;
   logic          hold_rdy;

   task automatic stream(input string tag, input int n, input int hold, input int budget);
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      max_out   = 0;
      hold_sent = 0;
      hold_rdy  = 1'b0;
      while ((got < n) && (cyc < budget)) begin
         out_ready = (cyc >= hold);
         if (cyc == hold) begin
            hold_sent = sent;
            hold_rdy  = in_ready;
         end
         in_valid = (sent < n);
         if (sent < n) begin
            in_data = vec_in[sent];
            in_last = last_in[sent];
         end
         if (out_valid && out_ready) begin
            check32({tag, "_data"}, out_data, vec_exp[got]);
            check1({tag, "_last"}, out_last, last_in[got]);
            got++;
         end
         if (in_valid && in_ready) sent++;
         if ((sent - got) > max_out) max_out = sent - got;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check32({tag, "_delivered"}, 32'(got), 32'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, required finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int early;
      int seen;
      int dcnt;
      set_w(1'b0);

      // Reset values
      #2 rst = 1'b1;
      #1;
      check1("rst_in_ready", in_ready, 1'b1);
      check32("rst_sa_inputs", sa_inputs, 32'h0);
      check1("rst_out_valid", out_valid, 1'b0);
      check32("rst_out_data", out_data, 32'h0);
      check1("rst_out_last", out_last, 1'b0);
      check1("rst_busy", busy, 1'b0);
      check1("rst_done", done, 1'b0);
      check1("rst_sa_resetn", sa_resetn, 1'b0);
      tick(); tick();
      rst = 1'b0;
      #1;
      check1("sa_resetn_release", sa_resetn, 1'b1);

      // Identity weights, single vector, latency 8
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'h04030201; in_last = 1'b0;
      tick();
      in_valid = 1'b0;
      check32("t1_skew_row0", sa_inputs, 32'h00000001);
      check1("t1_busy", busy, 1'b1);
      tick();
      check32("t1_skew_row1", sa_inputs, 32'h00000200);
      early = 0;
      for (int i = 2; i < 8; i++) begin
         tick();
         if (out_valid) early++;
      end
      check32("t1_no_early_out", 32'(early), 32'd0);
      tick();
      check1("t1_out_valid", out_valid, 1'b1);
      check32("t1_out_data", out_data, 32'h04030201);
      check1("t1_out_last", out_last, 1'b0);
      tick();
      check1("t1_popped", out_valid, 1'b0);

      // All-ones weights: modulo wrap, then identity back-to-back vectors
      do_reset();
      set_w(1'b1);
      vec_in[0] = 32'h00646464; vec_exp[0] = 32'h2c2c2c2c; last_in[0] = 1'b0;
      stream("t2_sum", 1, 0, 40);
      set_w(1'b0);
      for (int i = 0; i < 6; i++) begin
         vec_in[i] = rep(i + 1); vec_exp[i] = rep(i + 1); last_in[i] = 1'b0;
      end
      stream("t2_seq", 6, 0, 100);

      // Back-pressure: 10 vectors into a stalled consumer
      do_reset();
      for (int i = 0; i < 10; i++) begin
         vec_in[i] = rep(i + 11); vec_exp[i] = rep(i + 11); last_in[i] = 1'b0;
      end
      stream("t3_bp", 10, 20, 200);
      check32("t3_accepted_while_stalled", 32'(hold_sent), 32'd4);
      check1("t3_ready_while_stalled", hold_rdy, 1'b0);
      check32("t3_max_outstanding", 32'(max_out), 32'd4);

      // Job end: three vectors, last tagged
      do_reset();
      out_ready = 1'b1;
      check1("t4_busy_idle", busy, 1'b0);
      in_valid = 1'b1; in_data = 32'h0a0b0c0d; in_last = 1'b0;
      tick();
      check1("t4_busy_run", busy, 1'b1);
      in_data = 32'h1a1b1c1d;
      tick();
      in_data = 32'h2a2b2c2d; in_last = 1'b1;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      check1("t4_ready_drain", in_ready, 1'b0);
      check1("t4_busy_drain", busy, 1'b1);
      seen = 0; dcnt = 0;
      for (int i = 0; (i < 20) && (seen < 3); i++) begin
         if (done) dcnt++;
         if (out_valid) begin
            check32("t4_out_data", out_data, (seen == 0) ? 32'h0a0b0c0d :
                                             (seen == 1) ? 32'h1a1b1c1d : 32'h2a2b2c2d);
            check1("t4_out_last", out_last, seen == 2);
            check1("t4_done_with_last", done, seen == 2);
            seen++;
         end
         tick();
      end
      check32("t4_outputs", 32'(seen), 32'd3);
      check32("t4_done_pulses", 32'(dcnt), 32'd1);
      check1("t4_done_low", done, 1'b0);
      check1("t4_busy_after", busy, 1'b0);
      check1("t4_ready_after", in_ready, 1'b1);

      // Reset mid-stream
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'h01010101;
      tick();
      in_data = 32'h02020202;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      check1("t5_rst_in_ready", in_ready, 1'b1);
      check32("t5_rst_sa_inputs", sa_inputs, 32'h0);
      check1("t5_rst_out_valid", out_valid, 1'b0);
      check32("t5_rst_out_data", out_data, 32'h0);
      check1("t5_rst_busy", busy, 1'b0);
      check1("t5_rst_sa_resetn", sa_resetn, 1'b0);
      tick(); tick();
      rst = 1'b0;
      early = 0;
      in_valid = 1'b1; in_data = 32'h08070605;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) early++;
         tick();
      end
      check32("t5_no_stale", 32'(early), 32'd0);
      check1("t5_out_valid", out_valid, 1'b1);
      check32("t5_out_data", out_data, 32'h08070605);

      // Simultaneous push/pop at 3 of 4 entries, pointers wrap
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         in_valid = 1'b1; in_data = rep(k);
         check1("t6_pre_ready", in_ready, 1'b1);
         tick();
      end
      in_valid = 1'b0;
      repeat (10) tick();
      check1("t6_pre_valid", out_valid, 1'b1);
      check32("t6_pre_head", out_data, rep(1));
      for (int k = 4; k <= 23; k++) begin
         in_valid = 1'b1; in_data = rep(k);
         check1("t6_ready", in_ready, 1'b1);
         tick();
         in_valid = 1'b0;
         repeat (7) tick();
         out_ready = 1'b1;
         check32("t6_head", out_data, rep(k - 3));
         tick();
         out_ready = 1'b0;
      end
      check1("t6_ready_end", in_ready, 1'b1);
      out_ready = 1'b1;
      for (int k = 21; k <= 23; k++) begin
         check1("t6_drain_valid", out_valid, 1'b1);
         check32("t6_drain_data", out_data, rep(k));
         tick();
      end
      check1("t6_empty", out_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
